cp0_unit: RTL and testbench



---
 rtl/cp0_pkg.sv | 29 ++
 rtl/cp0_timer.sv | 42 ++++
 rtl/cp0_unit.sv | 132 +++++++++++++
 tb/tb_cp0_unit.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Coprocessor-0 shared definitions.
// Register numbers, exception codes and bit positions.
package cp0_pkg;

    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    localparam logic [4:0] EXC_INT = 5'd0;
    localparam logic [4:0] EXC_SYS = 5'd8;

    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;
    localparam int ST_IM_HI = 15;

    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;
    localparam int CA_IP_LO  = 10;
    localparam int CA_IP_HI  = 15;
    localparam int CA_TIMER  = 15;

    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0800;
    localparam logic [31:0] DEF_PRID       = 32'h0000_0001;

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the sticky timer interrupt flag.
// Count free-runs and wraps; a Compare write clears the flag.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_count,
    input  logic        wr_compare,
    input  logic [31:0] wr_data,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_irq
);

    logic hit;

    // match is only meaningful for a non-zero Compare
    always_comb begin
        hit = (count == compare) && (compare != 32'd0);
    end

    // counter, compare register and flag; clear beats set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 32'd0;
            compare   <= 32'd0;
            timer_irq <= 1'b0;
        end else begin
            if (wr_count) begin
                count <= wr_data;
            end else begin
                count <= count + 32'd1;
            end
            if (wr_compare) begin
                compare   <= wr_data;
                timer_irq <= 1'b0;
            end else if (hit) begin
                timer_irq <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: status/cause/EPC, interrupt and
// syscall entry, ERET, and the PC-redirect request.
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] PRID       = DEF_PRID
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtc0,
    input  logic        mfc0,
    input  logic        exce_ret,
    input  logic        sys,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] pc,
    input  logic [4:0]  hw_int,
    output logic [31:0] rd_data,
    output logic        exc_taken,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_irq;
    logic [7:0]  im;
    logic        exl;
    logic        ie;
    logic [4:0]  ip_hw;
    logic [4:0]  exc_code;
    logic [31:0] epc;
    logic [31:0] status_val;
    logic [31:0] cause_val;
    logic        int_req;
    logic        eret;
    logic        wr_en;
    logic        wr_count;
    logic        wr_compare;
    logic        unused_mfc0;

    // reads are unconditional, so the read strobe carries no work
    assign unused_mfc0 = mfc0;

    // pending interrupt and per-cycle arbitration of the strobes
    always_comb begin
        int_req = ie & ~exl
                & (|({timer_irq, ip_hw} & im[7:2]));
        exc_taken = ~rst & (int_req | sys);
        eret = ~rst & exce_ret & ~exc_taken;
        wr_en = ~rst & mtc0 & ~exc_taken & ~exce_ret;
        wr_count = wr_en && (rd_addr == REG_COUNT);
        wr_compare = wr_en && (rd_addr == REG_COMPARE);
        redirect = exc_taken | eret;
        if (exc_taken) begin
            redirect_pc = EXC_VECTOR;
        end else if (eret) begin
            redirect_pc = epc;
        end else begin
            redirect_pc = 32'd0;
        end
    end

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .wr_count   (wr_count),
        .wr_compare (wr_compare),
        .wr_data    (wr_data),
        .count      (count),
        .compare    (compare),
        .timer_irq  (timer_irq)
    );

    // architectural views of Status and Cause
    always_comb begin
        status_val = 32'd0;
        status_val[ST_IM_HI:ST_IM_LO] = im;
        status_val[ST_EXL] = exl;
        status_val[ST_IE] = ie;
        cause_val = 32'd0;
        cause_val[CA_TIMER] = timer_irq;
        cause_val[CA_IP_HI-1:CA_IP_LO] = ip_hw;
        cause_val[CA_EXC_HI:CA_EXC_LO] = exc_code;
    end

    // read mux shows pre-edge state
    always_comb begin
        case (rd_addr)
            REG_COUNT:   rd_data = count;
            REG_COMPARE: rd_data = compare;
            REG_STATUS:  rd_data = status_val;
            REG_CAUSE:   rd_data = cause_val;
            REG_EPC:     rd_data = epc;
            REG_PRID:    rd_data = PRID;
            default:     rd_data = 32'd0;
        endcase
    end

    // exception entry beats ERET, which beats software writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im       <= 8'd0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            ip_hw    <= 5'd0;
            exc_code <= 5'd0;
            epc      <= 32'd0;
        end else begin
            ip_hw <= hw_int;
            if (exc_taken) begin
                epc      <= pc;
                exl      <= 1'b1;
                exc_code <= int_req ? EXC_INT : EXC_SYS;
            end else if (eret) begin
                exl <= 1'b0;
            end else if (wr_en) begin
                case (rd_addr)
                    REG_STATUS: begin
                        im  <= wr_data[ST_IM_HI:ST_IM_LO];
                        exl <= wr_data[ST_EXL];
                        ie  <= wr_data[ST_IE];
                    end
                    REG_EPC: epc <= wr_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus
// randomized traffic against a word-level reference model.
module tb_cp0_unit;

    logic        clk;
    logic        rst;
    logic        mtc0;
    logic        mfc0;
    logic        exce_ret;
    logic        sys;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic [31:0] pc;
    logic [4:0]  hw_int;
    logic [31:0] rd_data;
    logic        exc_taken;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks;
    int errors;

    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic [31:0] m_status;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    cp0_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mtc0        (mtc0),
        .mfc0        (mfc0),
        .exce_ret    (exce_ret),
        .sys         (sys),
        .rd_addr     (rd_addr),
        .wr_data     (wr_data),
        .pc          (pc),
        .hw_int      (hw_int),
        .rd_data     (rd_data),
        .exc_taken   (exc_taken),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0001;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_int();
        return m_status[0] && !m_status[1]
            && ((m_cause & m_status & 32'h0000_FC00) != 0);
    endfunction

    task automatic model_zero();
        m_count = 0;
        m_compare = 0;
        m_status = 0;
        m_cause = 0;
        m_epc = 0;
    endtask

    task automatic model_update();
        logic intr, exc, eret, wr, t;
        logic [4:0] code;
        if (rst) begin
            model_zero();
            return;
        end
        intr = m_int();
        exc = intr || sys;
        eret = exce_ret && !exc;
        wr = mtc0 && !exc && !exce_ret;
        t = m_cause[15];
        if (wr && rd_addr == 5'd11) t = 1'b0;
        else if (m_count == m_compare && m_compare != 0) t = 1'b1;
        code = m_cause[6:2];
        if (exc) code = intr ? 5'd0 : 5'd8;
        m_cause = (32'(t) << 15) | (32'(hw_int) << 10) | (32'(code) << 2);
        if (exc) m_status = m_status | 32'h2;
        else if (eret) m_status = m_status & ~32'h2;
        else if (wr && rd_addr == 5'd12) m_status = wr_data & 32'h0000_FF03;
        if (exc) m_epc = pc;
        else if (wr && rd_addr == 5'd14) m_epc = wr_data;
        if (wr && rd_addr == 5'd11) m_compare = wr_data;
        if (wr && rd_addr == 5'd9) m_count = wr_data;
        else m_count = m_count + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        mtc0 = 0;
        mfc0 = 0;
        exce_ret = 0;
        sys = 0;
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        rd_addr = a;
        #1;
        v = rd_data;
    endtask

    task automatic write(input logic [4:0] a, input logic [31:0] d);
        idle();
        mtc0 = 1;
        rd_addr = a;
        wr_data = d;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #1;
        peek(5'd9, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL rst_count: got %h want 0", v);
        end
        checks++;
        if (redirect !== 1'b0 || exc_taken !== 1'b0) begin
            errors++;
            $display("FAIL rst_outs: got %b%b want 00", redirect, exc_taken);
        end
        @(negedge clk);
        rst = 0;
        write(5'd9, 32'h1234);
        tick();
        write(5'd12, 32'h2);
        tick();
        idle();
        peek(5'd9, v);
        checks++;
        if (v !== 32'h1235) begin
            errors++;
            $display("FAIL pre_rst_count: got %h want 1235", v);
        end
        peek(5'd12, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL pre_rst_status: got %h want 2", v);
        end
        rst = 1;
        #1;
        model_zero();
        peek(5'd12, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL async_rst_status: got %h want 0", v);
        end
        peek(5'd9, v);
        checks++;
        if (v !== 32'd0 || redirect !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_count: got %h/%b want 0/0", v, redirect);
        end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_syscall_eret();
        logic [31:0] v;
        idle();
        sys = 1;
        pc = 32'h40;
        #1;
        checks++;
        if (exc_taken !== 1'b1 || redirect !== 1'b1
            || redirect_pc !== 32'h800) begin
            errors++;
            $display("FAIL sys_entry: got %b %b %h want 1 1 800",
                     exc_taken, redirect, redirect_pc);
        end
        tick();
        idle();
        peek(5'd14, v);
        checks++;
        if (v !== 32'h40) begin
            errors++;
            $display("FAIL sys_epc: got %h want 40", v);
        end
        peek(5'd13, v);
        checks++;
        if (v !== 32'h20) begin
            errors++;
            $display("FAIL sys_cause: got %h want 20", v);
        end
        peek(5'd12, v);
        checks++;
        if (v !== 32'h2) begin
            errors++;
            $display("FAIL sys_exl: got %h want 2", v);
        end
        tick();
        exce_ret = 1;
        #1;
        checks++;
        if (redirect !== 1'b1 || exc_taken !== 1'b0
            || redirect_pc !== 32'h40) begin
            errors++;
            $display("FAIL eret_redirect: got %b %b %h want 1 0 40",
                     redirect, exc_taken, redirect_pc);
        end
        tick();
        idle();
        peek(5'd12, v);
        checks++;
        if (v !== 32'd0) begin
            errors++;
            $display("FAIL eret_exl: got %h want 0", v);
        end
        tick();
    endtask

    task automatic test_interrupt();
        logic [31:0] v;
        hw_int = 5'b00001;
        write(5'd12, 32'h401);
        #1;
        checks++;
        if (exc_taken !== 1'b0) begin
            errors++;
            $display("FAIL int_early: got %b want 0", exc_taken);
        end
        tick();
        idle();
        pc = 32'h100;
        #1;
        checks++;
        if (exc_taken !== 1'b1 || redirect_pc !== 32'h800) begin
            errors++;
            $display("FAIL int_entry: got %b %h want 1 800",
                     exc_taken, redirect_pc);
        end
        tick();
        peek(5'd14, v);
        checks++;
        if (v !== 32'h100) begin
            errors++;
            $display("FAIL int_epc: got %h want 100", v);
        end
        peek(5'd13, v);
        checks++;
        if (v !== 32'h400) begin
            errors++;
            $display("FAIL int_cause: got %h want 400", v);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            checks++;
            if (exc_taken !== 1'b0) begin
                errors++;
                $display("FAIL int_nested: got %b want 0", exc_taken);
            end
        end
        write(5'd12, 32'h0);
        tick();
        idle();
        hw_int = 0;
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] v;
        write(5'd12, 32'h401);
        tick();
        idle();
        hw_int = 5'b00001;
        #1;
        checks++;
        if (exc_taken !== 1'b0) begin
            errors++;
            $display("FAIL prio_pre: got %b want 0", exc_taken);
        end
        tick();
        hw_int = 0;
        write(5'd11, 32'h77);
        sys = 1;
        pc = 32'h200;
        #1;
        checks++;
        if (exc_taken !== 1'b1 || redirect_pc !== 32'h800) begin
            errors++;
            $display("FAIL prio_entry: got %b %h want 1 800",
                     exc_taken, redirect_pc);
        end
        tick();
        idle();
        peek(5'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL prio_code: got %h want 0", v);
        end
        peek(5'd11, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL prio_mtc0: got %h want 0", v);
        end
        peek(5'd14, v);
        checks++;
        if (v !== 32'h200) begin
            errors++;
            $display("FAIL prio_epc: got %h want 200", v);
        end
        write(5'd12, 32'h0);
        tick();
        idle();
    endtask

    task automatic test_timer();
        logic [31:0] v;
        logic [31:0] want;
        write(5'd9, 32'hFFFF_FFFE);
        tick();
        write(5'd11, 32'h1);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            want = 32'hFFFF_FFFF + 32'(i);
            peek(5'd9, v);
            checks++;
            if (v !== want) begin
                errors++;
                $display("FAIL tmr_count%0d: got %h want %h", i, v, want);
            end
            peek(5'd13, v);
            checks++;
            if (v[15] !== 1'b0) begin
                errors++;
                $display("FAIL tmr_early%0d: got %b want 0", i, v[15]);
            end
            tick();
        end
        peek(5'd13, v);
        checks++;
        if (v !== 32'h8000) begin
            errors++;
            $display("FAIL tmr_set: got %h want 8000", v);
        end
        tick();
        peek(5'd13, v);
        checks++;
        if (v !== 32'h8000) begin
            errors++;
            $display("FAIL tmr_sticky: got %h want 8000", v);
        end
        write(5'd11, 32'h5);
        tick();
        idle();
        peek(5'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL tmr_clear: got %h want 0", v);
        end
        write(5'd11, 32'h0);
        tick();
        idle();
    endtask

    task automatic test_reads();
        logic [31:0] v;
        peek(5'd15, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL rd_prid: got %h want 1", v);
        end
        peek(5'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL rd_unmapped: got %h want 0", v);
        end
        write(5'd13, 32'hFFFF_FFFF);
        tick();
        write(5'd15, 32'hFFFF_FFFF);
        tick();
        write(5'd3, 32'hFFFF_FFFF);
        tick();
        idle();
        peek(5'd13, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL wr_cause: got %h want 0", v);
        end
        peek(5'd15, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL wr_prid: got %h want 1", v);
        end
        peek(5'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL wr_unmapped: got %h want 0", v);
        end
        tick();
    endtask

    task automatic test_random();
        logic [4:0] addrs [7];
        logic [31:0] want;
        logic w_exc, w_red;
        int r;
        addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
        for (int n = 0; n < 400; n++) begin
            idle();
            r = int'($urandom % 16);
            mtc0 = (r < 4);
            sys = (r == 4);
            exce_ret = (r == 5);
            mfc0 = $urandom % 2 == 0;
            rd_addr = addrs[$urandom % 7];
            if (rd_addr == 5'd0) rd_addr = 5'($urandom);
            wr_data = $urandom;
            if (rd_addr == 5'd11) wr_data = m_count + ($urandom % 8);
            if (rd_addr == 5'd12) wr_data = wr_data & 32'hFFFF_FFFD;
            pc = {$urandom, 2'b00} & 32'h000F_FFFC;
            hw_int = ($urandom % 4 == 0) ? 5'($urandom) : 5'd0;
            #1;
            w_exc = m_int() || sys;
            w_red = w_exc || exce_ret;
            want = m_read(rd_addr);
            checks++;
            if (rd_data !== want) begin
                errors++;
                $display("FAIL rnd_rd%0d a=%0d: got %h want %h",
                         n, rd_addr, rd_data, want);
            end
            checks++;
            if (exc_taken !== w_exc || redirect !== w_red) begin
                errors++;
                $display("FAIL rnd_ctl%0d: got %b%b want %b%b",
                         n, exc_taken, redirect, w_exc, w_red);
            end
            if (w_red) begin
                want = w_exc ? 32'h800 : m_epc;
                checks++;
                if (redirect_pc !== want) begin
                    errors++;
                    $display("FAIL rnd_pc%0d: got %h want %h",
                             n, redirect_pc, want);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        mtc0 = 0;
        mfc0 = 0;
        exce_ret = 0;
        sys = 0;
        rd_addr = 0;
        wr_data = 0;
        pc = 0;
        hw_int = 0;
        model_zero();
        repeat (2) @(negedge clk);
        test_reset();
        test_syscall_eret();
        test_interrupt();
        test_priority();
        test_timer();
        test_reads();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
